// File: rtl/wdt_reg_bridge.sv
// Register front-end for the watchdog timer: turns single-outstanding bus requests into
// valid/ready config transfers on the enable, kick and timeout-count channels.
module wdt_reg_bridge #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              wden_valid,
  input  logic              wden_ready,
  output logic              wden,
  output logic              wdlive_valid,
  input  logic              wdlive_ready,
  output logic              wdlive,
  output logic              wtocnt_valid,
  input  logic              wtocnt_ready,
  output logic [31:0]       wtocnt,
  input  logic              wdt_irq
);

  localparam int unsigned CNT_W = (CH_TIMEOUT > 0) ? $clog2(CH_TIMEOUT + 1) : 1;
  localparam int unsigned LAST  = (CH_TIMEOUT > 0) ? CH_TIMEOUT - 1 : 0;

  localparam logic [3:0] A_EN     = 4'h0;
  localparam logic [3:0] A_LIVE   = 4'h4;
  localparam logic [3:0] A_TOCNT  = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               en_shadow, en_shadow_n;
  logic [31:0]        tocnt_shadow, tocnt_shadow_n;
  logic               sticky, sticky_n;
  logic               rsp_valid_n, rsp_err_n;
  logic [31:0]        rsp_rdata_n;
  logic               wden_valid_n, wdlive_valid_n, wtocnt_valid_n;
  logic               wden_n, wdlive_n;
  logic [31:0]        wtocnt_n;

  logic [31:0]        addr_ext;
  logic               addr_bad;
  logic [31:0]        status;
  logic               hs;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    addr_ext       = 32'(req_addr);
    addr_bad       = (addr_ext[31:4] != '0) || (addr_ext[1:0] != 2'b00);
    status         = {29'b0, sticky, wdt_irq, en_shadow};
    hs             = (wden_valid & wden_ready) | (wdlive_valid & wdlive_ready) |
                     (wtocnt_valid & wtocnt_ready);
    state_n        = state;
    cnt_n          = cnt;
    en_shadow_n    = en_shadow;
    tocnt_shadow_n = tocnt_shadow;
    sticky_n       = sticky;
    rsp_valid_n    = rsp_valid;
    rsp_err_n      = rsp_err;
    rsp_rdata_n    = rsp_rdata;
    wden_valid_n   = wden_valid;
    wdlive_valid_n = wdlive_valid;
    wtocnt_valid_n = wtocnt_valid;
    wden_n         = wden;
    wdlive_n       = wdlive;
    wtocnt_n       = wtocnt;

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (addr_bad || (req_write && addr_ext[3:0] == A_STATUS)) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end else if (!req_write) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
            case (addr_ext[3:0])
              A_EN:     rsp_rdata_n = {31'b0, en_shadow};
              A_TOCNT:  rsp_rdata_n = tocnt_shadow;
              A_STATUS: begin
                rsp_rdata_n = status;
                sticky_n    = 1'b0;
              end
              default:  rsp_rdata_n = '0;
            endcase
          end else begin
            state_n = S_ISSUE;
            cnt_n   = '0;
            case (addr_ext[3:0])
              A_EN: begin
                wden_valid_n = 1'b1;
                wden_n       = req_wdata[0];
              end
              A_LIVE: begin
                wdlive_valid_n = 1'b1;
                wdlive_n       = req_wdata[0];
              end
              default: begin
                wtocnt_valid_n = 1'b1;
                wtocnt_n       = req_wdata;
              end
            endcase
          end
        end
      end

      S_ISSUE: begin
        // cnt counts cycles already waited; the abort lands on the edge where it would reach
        // CH_TIMEOUT, so valid is up CH_TIMEOUT cycles and a ready on the last one still wins.
        if (hs) begin
          if (wden_valid)   en_shadow_n    = wden;
          if (wtocnt_valid) tocnt_shadow_n = wtocnt;
          wden_valid_n   = 1'b0;
          wdlive_valid_n = 1'b0;
          wtocnt_valid_n = 1'b0;
          state_n        = S_RESP;
          rsp_valid_n    = 1'b1;
          rsp_err_n      = 1'b0;
          rsp_rdata_n    = '0;
        end else if (CH_TIMEOUT != 0 && cnt == CNT_W'(LAST)) begin
          wden_valid_n   = 1'b0;
          wdlive_valid_n = 1'b0;
          wtocnt_valid_n = 1'b0;
          sticky_n       = 1'b1;
          state_n        = S_RESP;
          rsp_valid_n    = 1'b1;
          rsp_err_n      = 1'b1;
          rsp_rdata_n    = '0;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      en_shadow    <= 1'b0;
      tocnt_shadow <= '0;
      sticky       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      wden_valid   <= 1'b0;
      wdlive_valid <= 1'b0;
      wtocnt_valid <= 1'b0;
      wden         <= 1'b0;
      wdlive       <= 1'b0;
      wtocnt       <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      en_shadow    <= en_shadow_n;
      tocnt_shadow <= tocnt_shadow_n;
      sticky       <= sticky_n;
      rsp_valid    <= rsp_valid_n;
      rsp_err      <= rsp_err_n;
      rsp_rdata    <= rsp_rdata_n;
      wden_valid   <= wden_valid_n;
      wdlive_valid <= wdlive_valid_n;
      wtocnt_valid <= wtocnt_valid_n;
      wden         <= wden_n;
      wdlive       <= wdlive_n;
      wtocnt       <= wtocnt_n;
    end
  end

endmodule

// File: tb/tb_wdt_reg_bridge.sv
// Directed bench for wdt_reg_bridge: register map, channel handshakes, timeout abort,
// address errors, response backpressure and mid-transaction reset.
module tb_wdt_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wden_valid, wden_ready, wden;
  logic        wdlive_valid, wdlive_ready, wdlive;
  logic        wtocnt_valid, wtocnt_ready;
  logic [31:0] wtocnt;
  logic        wdt_irq;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  wdt_reg_bridge #(.ADDR_W(5), .CH_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wden_valid(wden_valid), .wden_ready(wden_ready), .wden(wden),
    .wdlive_valid(wdlive_valid), .wdlive_ready(wdlive_ready), .wdlive(wdlive),
    .wtocnt_valid(wtocnt_valid), .wtocnt_ready(wtocnt_ready), .wtocnt(wtocnt),
    .wdt_irq(wdt_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] any_valid();
    return {29'b0, wtocnt_valid, wdlive_valid, wden_valid};
  endfunction

  // Presents a request in IDLE; returns at the sample point one cycle after acceptance.
  task automatic accept(input logic w, input logic [4:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    check("accept_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp_data,
                    input logic exp_err);
    accept(1'b0, a, 32'h0);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rdata"}, rsp_rdata, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_no_chan"}, any_valid(), 0);
    tick;
    check({tag, "_rsp_done"}, rsp_valid, 0);
  endtask

  task automatic wr_err(input string tag, input logic [4:0] a, input logic [31:0] d);
    accept(1'b1, a, d);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_err"}, rsp_err, 1);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_no_chan"}, any_valid(), 0);
    tick;
    check({tag, "_no_chan2"}, any_valid(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; wden_ready = 1'b0; wdlive_ready = 1'b0; wtocnt_ready = 1'b0;
    wdt_irq = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_valids", any_valid(), 0);
    check("rst_wtocnt", wtocnt, 0);
    check("rst_wden_wdlive", {wden, wdlive}, 0);
    check("rst_rdata_err", {rsp_err, rsp_rdata[30:0]}, 0);

    // T1: timeout-count write with ready already high
    wtocnt_ready = 1'b1;
    accept(1'b1, 5'h08, 32'h64);
    check("t1_valid_n1", wtocnt_valid, 1);
    check("t1_data_n1", wtocnt, 32'h64);
    check("t1_other_valid", {wden_valid, wdlive_valid}, 0);
    check("t1_rsp_n1", rsp_valid, 0);
    tick;
    check("t1_valid_n2", wtocnt_valid, 0);
    check("t1_rsp_n2", rsp_valid, 1);
    check("t1_err", rsp_err, 0);
    tick;
    check("t1_rsp_done", rsp_valid, 0);
    wtocnt_ready = 1'b0;
    rd("t1_rd_tocnt", 5'h08, 32'h64, 1'b0);

    // T2: enable write with ready low three cycles
    accept(1'b1, 5'h00, 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wden_ready = 1'b1;
      check("t2_valid_held", wden_valid, 1);
      check("t2_data_held", wden, 1);
      check("t2_no_rsp", rsp_valid, 0);
      tick;
    end
    wden_ready = 1'b0;
    check("t2_valid_drop", wden_valid, 0);
    check("t2_rsp", rsp_valid, 1);
    check("t2_err", rsp_err, 0);
    tick;
    rd("t2_status", 5'h0C, 32'h1, 1'b0);
    rd("t2_rd_en", 5'h00, 32'h1, 1'b0);

    // T3: kick write with ready stuck low times out after 4 cycles
    accept(1'b1, 5'h04, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t3_valid_held", wdlive_valid, 1);
      check("t3_data_held", wdlive, 1);
      tick;
    end
    check("t3_valid_drop", wdlive_valid, 0);
    check("t3_rsp", rsp_valid, 1);
    check("t3_err", rsp_err, 1);
    tick;
    rd("t3_status_sticky", 5'h0C, 32'h5, 1'b0);
    rd("t3_status_clear", 5'h0C, 32'h1, 1'b0);
    rd("t3_rd_live", 5'h04, 32'h0, 1'b0);

    // ready arriving on the last allowed cycle wins over the timeout; data 0 forwarded
    accept(1'b1, 5'h04, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wdlive_ready = 1'b1;
      check("t3b_valid_held", wdlive_valid, 1);
      check("t3b_data_zero", wdlive, 0);
      tick;
    end
    wdlive_ready = 1'b0;
    check("t3b_valid_drop", wdlive_valid, 0);
    check("t3b_rsp", rsp_valid, 1);
    check("t3b_err", rsp_err, 0);
    tick;
    rd("t3b_status", 5'h0C, 32'h1, 1'b0);

    // T4: address and access errors
    rd("t4_unaligned", 5'h06, 32'h0, 1'b1);
    wr_err("t4_wr_status", 5'h0C, 32'h7);
    wr_err("t4_wr_upper", 5'h10, 32'h1);
    rd("t4_rd_upper", 5'h18, 32'h0, 1'b1);
    rd("t4_status", 5'h0C, 32'h1, 1'b0);

    // T5: response backpressure, then interrupt readback
    rsp_ready = 1'b0;
    accept(1'b0, 5'h08, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_held", rsp_valid, 1);
      check("t5_rdata_held", rsp_rdata, 32'h64);
      check("t5_err_held", rsp_err, 0);
      check("t5_req_blocked", req_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    check("t5_rsp_still", rsp_valid, 1);
    tick;
    check("t5_rsp_done", rsp_valid, 0);
    check("t5_req_ready", req_ready, 1);
    wdt_irq = 1'b1;
    rd("t5_status_irq", 5'h0C, 32'h3, 1'b0);
    wdt_irq = 1'b0;

    // T6: reset while a timeout-count transfer is pending
    accept(1'b1, 5'h08, 32'hABCD);
    check("t6_valid_pending", wtocnt_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_valids", any_valid(), 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_wtocnt", wtocnt, 0);
    rd("t6_rd_tocnt", 5'h08, 32'h0, 1'b0);
    rd("t6_rd_en", 5'h00, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
